// File: rtl/knn_dist_unit.sv
// Three-stage squared-Euclidean distance pipeline feeding knn_core.
// Holds one test point; emits (dist, label, last) per accepted dataset point, in order.
module knn_dist_unit #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  test_ld,
  input  logic [DATA_W/2-1:0]   test_x,
  input  logic [DATA_W/2-1:0]   test_y,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [DATA_W/2-1:0]   pt_x,
  input  logic [DATA_W/2-1:0]   pt_y,
  input  logic [LABEL_W-1:0]    pt_label,
  input  logic                  pt_last,
  output logic                  dist_valid,
  input  logic                  dist_ready,
  output logic [2*DATA_W-1:0]   dist_value,
  output logic [LABEL_W-1:0]    dist_label,
  output logic                  dist_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     pt_count
);

  localparam int HW    = DATA_W / 2;
  localparam int SQ_W  = DATA_W + 2;
  localparam int SUM_W = DATA_W + 3;

  logic [HW-1:0]       r_tx, r_ty;
  logic                r_v1, r_v2, r_v3;
  logic [HW:0]         r_dx1, r_dy1;
  logic [LABEL_W-1:0]  r_lab1, r_lab2, r_lab3;
  logic                r_last1, r_last2, r_last3;
  logic [SQ_W-1:0]     r_sqx2, r_sqy2;
  logic [2*DATA_W-1:0] r_dist3;
  logic [DATA_W-1:0]   r_count;
  logic                r_done;

  logic                w_stall, w_accept, w_out_hs;
  logic [HW:0]         w_dx, w_dy;
  logic [SQ_W-1:0]     w_dx_ext, w_dy_ext, w_sqx, w_sqy;
  logic [SUM_W-1:0]    w_sum;

  assign w_stall  = r_v3 & ~dist_ready;
  assign w_accept = pt_valid & ~w_stall;
  assign w_out_hs = r_v3 & dist_ready;

  // Differences carry one extra bit so the full signed range never wraps.
  assign w_dx = {pt_x[HW-1], pt_x} - {r_tx[HW-1], r_tx};
  assign w_dy = {pt_y[HW-1], pt_y} - {r_ty[HW-1], r_ty};

  // Squaring the sign-extended value modulo 2^SQ_W yields the exact non-negative square.
  assign w_dx_ext = {{(SQ_W-HW-1){r_dx1[HW]}}, r_dx1};
  assign w_dy_ext = {{(SQ_W-HW-1){r_dy1[HW]}}, r_dy1};
  assign w_sqx    = w_dx_ext * w_dx_ext;
  assign w_sqy    = w_dy_ext * w_dy_ext;
  assign w_sum    = {1'b0, r_sqx2} + {1'b0, r_sqy2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= '0;
      r_ty <= '0;
    end else if (test_ld && !busy) begin
      r_tx <= test_x;
      r_ty <= test_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (clr) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (!w_stall) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dx1   <= '0;
      r_dy1   <= '0;
      r_lab1  <= '0;
      r_last1 <= 1'b0;
      r_sqx2  <= '0;
      r_sqy2  <= '0;
      r_lab2  <= '0;
      r_last2 <= 1'b0;
      r_dist3 <= '0;
      r_lab3  <= '0;
      r_last3 <= 1'b0;
    end else if (!w_stall) begin
      r_dx1   <= w_dx;
      r_dy1   <= w_dy;
      r_lab1  <= pt_label;
      r_last1 <= pt_last;
      r_sqx2  <= w_sqx;
      r_sqy2  <= w_sqy;
      r_lab2  <= r_lab1;
      r_last2 <= r_last1;
      r_dist3 <= {{(2*DATA_W-SUM_W){1'b0}}, w_sum};
      r_lab3  <= r_lab2;
      r_last3 <= r_last2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count <= r_count + {{(DATA_W-1){1'b0}}, 1'b1};
      end
      r_done <= w_out_hs & r_last3;
    end
  end

  assign pt_ready   = ~w_stall;
  assign dist_valid = r_v3;
  assign dist_value = r_dist3;
  assign dist_label = r_lab3;
  assign dist_last  = r_last3;
  assign busy       = r_v1 | r_v2 | r_v3;
  assign done       = r_done;
  assign pt_count   = r_count;

endmodule
